// File: rtl/bitwise_pkg.sv
// Shared types and constants for the bitwise arbiter slice.
package bitwise_pkg;

   localparam int unsigned DATA_W = 64;

   typedef enum logic [1:0] {
      OP_AND    = 2'b00,
      OP_OR     = 2'b01,
      OP_XOR    = 2'b10,
      OP_PASS_A = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

endpackage

// File: rtl/bitwise_arbiter_if.sv
// Requester handshake plus shared bitwise-unit bus for the arbiter.
interface bitwise_arbiter_if;
   import bitwise_pkg::*;

   logic              req0;
   logic              req1;
   logic [DATA_W-1:0] A0;
   logic [DATA_W-1:0] B0;
   logic [DATA_W-1:0] A1;
   logic [DATA_W-1:0] B1;
   op_e               op0;
   op_e               op1;
   logic [DATA_W-1:0] lu_A;
   logic [DATA_W-1:0] lu_B;
   op_e               lu_op;
   logic [DATA_W-1:0] lu_out;
   logic [DATA_W-1:0] result;
   logic              done0;
   logic              done1;
   logic              busy;

   // Arbiter side.
   modport slave (
      input  req0, req1, A0, B0, A1, B1, op0, op1, lu_out,
      output lu_A, lu_B, lu_op, result, done0, done1, busy
   );

   // Requesters and shared unit side.
   modport master (
      output req0, req1, A0, B0, A1, B1, op0, op1, lu_out,
      input  lu_A, lu_B, lu_op, result, done0, done1, busy
   );

endinterface

// File: rtl/bitwise_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   // One-hot grant selection.
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/bitwise_arbiter.sv
// Arbitrates two requesters onto one shared combinational bitwise unit.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for a request; grants and registers operands
//   ST_SETTLE | operands held for SETTLE_CYCLES while the unit settles
//   ST_DONE   | one-cycle done pulse to the granted requester
module bitwise_arbiter
   import bitwise_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic              clk,
   input logic              reset,
   bitwise_arbiter_if.slave bus
);

   // Counter runs 0..SETTLE_CYCLES-1, so it never needs to hold SETTLE_CYCLES itself.
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] lu_a_q, lu_a_d;
   logic [DATA_W-1:0] lu_b_q, lu_b_d;
   op_e               lu_op_q, lu_op_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt_q, gnt_d;
   logic [1:0]        grant;

   rr_arb2 u_rr_arb2 (
      .req_i        ({bus.req1, bus.req0}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // State register; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lu_a_q       <= '0;
         lu_b_q       <= '0;
         lu_op_q      <= OP_AND;
         result_q     <= '0;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lu_a_q       <= lu_a_d;
         lu_b_q       <= lu_b_d;
         lu_op_q      <= lu_op_d;
         result_q     <= result_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
      end
   end

   // Next-state and datapath: requests are only looked at in IDLE, so no preemption.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lu_a_d       = lu_a_q;
      lu_b_d       = lu_b_q;
      lu_op_d      = lu_op_q;
      result_d     = result_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               state_d      = ST_SETTLE;
               cnt_d        = '0;
               gnt_d        = grant[1];
               last_grant_d = grant[1];
               lu_a_d       = grant[1] ? bus.A1  : bus.A0;
               lu_b_d       = grant[1] ? bus.B1  : bus.B0;
               lu_op_d      = grant[1] ? bus.op1 : bus.op0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d  = ST_DONE;
               result_d = bus.lu_out;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; done goes only to the granted requester.
   always_comb begin
      bus.busy  = (state_q != ST_IDLE);
      bus.done0 = (state_q == ST_DONE) && !gnt_q;
      bus.done1 = (state_q == ST_DONE) &&  gnt_q;
   end

   assign bus.lu_A   = lu_a_q;
   assign bus.lu_B   = lu_b_q;
   assign bus.lu_op  = lu_op_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_bitwise_arbiter.sv
module tb_bitwise_arbiter;
   import bitwise_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   typedef struct packed {
      logic              id;
      logic [DATA_W-1:0] res;
   } exp_t;

   exp_t exp_q[$];

   bitwise_arbiter_if if2 ();
   bitwise_arbiter_if if1 ();
   bitwise_arbiter_if if15 ();

   bitwise_arbiter #(.SETTLE_CYCLES(2))  dut   (.clk(clk), .reset(reset), .bus(if2));
   bitwise_arbiter #(.SETTLE_CYCLES(1))  dut1  (.clk(clk), .reset(reset), .bus(if1));
   bitwise_arbiter #(.SETTLE_CYCLES(15)) dut15 (.clk(clk), .reset(reset), .bus(if15));

   function automatic logic [DATA_W-1:0] lu_model(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input op_e op);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return a;
      endcase
   endfunction

   assign if2.lu_out  = lu_model(if2.lu_A,  if2.lu_B,  if2.lu_op);
   assign if1.lu_out  = lu_model(if1.lu_A,  if1.lu_B,  if1.lu_op);
   assign if15.lu_out = lu_model(if15.lu_A, if15.lu_B, if15.lu_op);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor on the SETTLE_CYCLES=2 instance.
   always @(negedge clk) begin
      if (if2.done0 && if2.done1) begin
         checks++;
         errors++;
         $display("FAIL done_both: done0=%0b done1=%0b required one-hot", if2.done0, if2.done1);
      end else if (if2.done0 || if2.done1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done0=%0b done1=%0b with nothing outstanding",
                     if2.done0, if2.done1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (if2.done1 !== e.id || if2.result !== e.res) begin
               errors++;
               $display("FAIL sb_result: got id=%0d result=%h required id=%0d result=%h",
                        if2.done1, if2.result, e.id, e.res);
            end
         end
      end
   end

   task automatic wait_done(input int budget, output int lat, output logic who);
      lat = -1;
      who = 1'b0;
      for (int k = 1; k <= budget && lat < 0; k++) begin
         @(negedge clk);
         if (if2.done0 || if2.done1) begin
            lat = k;
            who = if2.done1;
         end
      end
   endtask

   task automatic clear_inputs();
      if2.req0 = 0; if2.req1 = 0; if2.A0 = '0; if2.B0 = '0; if2.A1 = '0; if2.B1 = '0;
      if2.op0 = OP_AND; if2.op1 = OP_AND;
      if1.req0 = 0; if1.req1 = 0; if1.A0 = '0; if1.B0 = '0; if1.A1 = '0; if1.B1 = '0;
      if1.op0 = OP_AND; if1.op1 = OP_AND;
      if15.req0 = 0; if15.req1 = 0; if15.A0 = '0; if15.B0 = '0; if15.A1 = '0; if15.B1 = '0;
      if15.op0 = OP_AND; if15.op1 = OP_AND;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (if2.busy !== 1'b0 || if2.done0 !== 1'b0 || if2.done1 !== 1'b0 ||
          if2.lu_A !== '0 || if2.lu_B !== '0 || if2.result !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b done=%0b%0b lu_A=%h lu_B=%h result=%h required all 0",
                  if2.busy, if2.done1, if2.done0, if2.lu_A, if2.lu_B, if2.result);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int   lat;
      logic who;
      if2.A0 = 64'd8324; if2.B0 = 64'd7813266; if2.op0 = OP_AND; if2.req0 = 1'b1;
      exp_q.push_back('{id: 1'b0, res: 64'd8320});
      @(negedge clk);
      checks++;
      if (if2.lu_A !== 64'd8324 || if2.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_lu_A: lu_A=%0d busy=%0b required 8324 busy=1", if2.lu_A, if2.busy);
      end
      wait_done(8, lat, who);
      if2.req0 = 1'b0;
      checks++;
      if (lat !== 2 || who !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency: lat=%0d who=%0d required lat=3 who=0", lat + 1, who);
      end
      checks++;
      if (if2.result !== 64'd8320) begin
         errors++;
         $display("FAIL basic_result: result=%0d required 8320", if2.result);
      end
   endtask

   task automatic test_tie();
      int   lat;
      logic who;
      pulse_reset();
      if2.A0 = 64'h00FF_00FF_00FF_00FF; if2.B0 = 64'h0F0F_0F0F_0F0F_0F0F; if2.op0 = OP_OR;
      if2.A1 = 64'hAAAA_5555_AAAA_5555; if2.B1 = 64'hFFFF_0000_FFFF_0000; if2.op1 = OP_XOR;
      if2.req0 = 1'b1; if2.req1 = 1'b1;
      exp_q.push_back('{id: 1'b0, res: lu_model(if2.A0, if2.B0, OP_OR)});
      exp_q.push_back('{id: 1'b1, res: lu_model(if2.A1, if2.B1, OP_XOR)});
      wait_done(8, lat, who);
      if2.req0 = 1'b0;
      checks++;
      if (lat !== 3 || who !== 1'b0) begin
         errors++;
         $display("FAIL tie_first: lat=%0d who=%0d required lat=3 who=0", lat, who);
      end
      wait_done(8, lat, who);
      if2.req1 = 1'b0;
      checks++;
      if (lat !== 4 || who !== 1'b1) begin
         errors++;
         $display("FAIL tie_second: lat=%0d who=%0d required lat=4 who=1", lat, who);
      end
   endtask

   task automatic test_round_robin();
      int   lat;
      logic who;
      logic [DATA_W-1:0] a [4];
      logic [DATA_W-1:0] b [4];
      op_e  op [4];
      a[0] = 64'h1234_5678_9ABC_DEF0; b[0] = 64'h0F0F_F0F0_0000_1111; op[0] = OP_OR;
      a[1] = 64'hDEAD_BEEF_CAFE_F00D; b[1] = 64'hFFFF_FFFF_0000_0000; op[1] = OP_XOR;
      a[2] = 64'h0BAD_C0DE_1357_9BDF; b[2] = 64'hFFFF_FFFF_FFFF_FFFF; op[2] = OP_PASS_A;
      a[3] = 64'h8000_0000_0000_0001; b[3] = 64'hC000_0000_0000_0003; op[3] = OP_AND;
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{id: i[0], res: lu_model(a[i], b[i], op[i])});
      if2.A0 = a[0]; if2.B0 = b[0]; if2.op0 = op[0];
      if2.A1 = a[1]; if2.B1 = b[1]; if2.op1 = op[1];
      if2.req0 = 1'b1; if2.req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_done(8, lat, who);
         checks++;
         if (lat < 0 || who !== i[0]) begin
            errors++;
            $display("FAIL rr_order[%0d]: lat=%0d who=%0d required who=%0d", i, lat, who, i[0]);
         end
         case (i)
            0: begin if2.A0 = a[2]; if2.B0 = b[2]; if2.op0 = op[2]; end
            1: begin if2.A1 = a[3]; if2.B1 = b[3]; if2.op1 = op[3]; end
            2: if2.req0 = 1'b0;
            default: if2.req1 = 1'b0;
         endcase
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      if2.A0 = 64'h5555; if2.B0 = 64'h3333; if2.op0 = OP_XOR; if2.req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (if2.busy !== 1'b1 || if2.lu_A !== 64'h5555) begin
         errors++;
         $display("FAIL abort_pre: busy=%0b lu_A=%h required busy=1 lu_A=5555", if2.busy, if2.lu_A);
      end
      reset = 1'b1;
      if2.req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (if2.busy !== 1'b0 || if2.result !== '0 || if2.lu_A !== '0 || if2.lu_B !== '0 ||
          if2.lu_op !== OP_AND || if2.done0 !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%0b result=%h lu_A=%h lu_B=%h lu_op=%0d done0=%0b required 0",
                  if2.busy, if2.result, if2.lu_A, if2.lu_B, if2.lu_op, if2.done0);
      end
      reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (if2.done0 || if2.done1) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL abort_no_done: dones=%0d required 0", dones);
      end
   endtask

   task automatic test_drop_req();
      int   lat;
      logic who;
      if2.A0 = 64'hF0F0_0000_1111_2222; if2.B0 = 64'h0FF0_FFFF_0101_0202; if2.op0 = OP_OR;
      if2.req0 = 1'b1;
      exp_q.push_back('{id: 1'b0, res: lu_model(if2.A0, if2.B0, OP_OR)});
      @(negedge clk);
      if2.req0 = 1'b0;
      wait_done(8, lat, who);
      checks++;
      if (lat !== 2 || who !== 1'b0) begin
         errors++;
         $display("FAIL drop_complete: lat=%0d who=%0d required lat=3 who=0", lat + 1, who);
      end
      if2.A0 = 64'h0123_4567_89AB_CDEF; if2.B0 = 64'hFEDC_BA98_7654_3210; if2.op0 = OP_XOR;
      if2.req0 = 1'b1;
      exp_q.push_back('{id: 1'b0, res: lu_model(if2.A0, if2.B0, OP_XOR)});
      exp_q.push_back('{id: 1'b0, res: lu_model(if2.A0, if2.B0, OP_XOR)});
      wait_done(8, lat, who);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL held_first: lat=%0d required 4", lat);
      end
      wait_done(8, lat, who);
      if2.req0 = 1'b0;
      checks++;
      if (lat !== 4 || who !== 1'b0) begin
         errors++;
         $display("FAIL held_second: lat=%0d who=%0d required lat=4 who=0", lat, who);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_settle_params();
      int lat1;
      int lat15;
      if1.A0  = 64'hFFFF_0000_FFFF_0000; if1.B0  = 64'h00FF_00FF_00FF_00FF; if1.op0  = OP_AND;
      if15.A1 = 64'h1111_2222_3333_4444; if15.B1 = 64'h8888_4444_2222_1111; if15.op1 = OP_OR;
      if1.req0 = 1'b1; if15.req1 = 1'b1;
      lat1 = -1; lat15 = -1;
      for (int k = 1; k <= 30 && (lat1 < 0 || lat15 < 0); k++) begin
         @(negedge clk);
         if (lat1 < 0 && if1.done0) begin lat1 = k; if1.req0 = 1'b0; end
         if (lat15 < 0 && if15.done1) begin lat15 = k; if15.req1 = 1'b0; end
      end
      checks++;
      if (lat1 !== 2) begin
         errors++;
         $display("FAIL settle1_latency: lat=%0d required 2", lat1);
      end
      checks++;
      if (lat15 !== 16) begin
         errors++;
         $display("FAIL settle15_latency: lat=%0d required 16", lat15);
      end
      checks++;
      if (if1.result !== 64'h00FF_0000_00FF_0000 || if15.result !== 64'h9999_6666_3333_5555) begin
         errors++;
         $display("FAIL settle_results: r1=%h r15=%h required 00ff000000ff0000 9999666633335555",
                  if1.result, if15.result);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_basic();
      test_tie();
      test_round_robin();
      test_reset_abort();
      test_drop_req();
      test_settle_params();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: outstanding=%0d required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
